// File: rtl/data_stack.sv
// LIFO data stack for the accumulator datapath: push/pop/replace with a registered
// top-of-stack word, occupancy count and sticky overflow/underflow flags.
module data_stack #(
  parameter int NBDATA = 32,
  parameter int SDEPTH = 10,
  parameter int NBCNT  = $clog2(SDEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dsp_push,
  input  logic              dsp_pop,
  input  logic              clr,
  input  logic [NBDATA-1:0] data_in,
  output logic [NBDATA-1:0] data_out,
  output logic [NBCNT-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              udf
);

  localparam int NBIDX = $clog2(SDEPTH);
  localparam logic [NBCNT-1:0] DEPTH_C = NBCNT'(SDEPTH);
  localparam logic [NBCNT-1:0] ONE_C   = NBCNT'(1);
  localparam logic [NBCNT-1:0] TWO_C   = NBCNT'(2);

  logic [NBDATA-1:0] r_mem [SDEPTH];
  logic [NBCNT-1:0]  r_count;
  logic [NBDATA-1:0] r_top;
  logic              r_ovf;
  logic              r_udf;

  logic              w_push_only;
  logic              w_pop_only;
  logic              w_replace;
  logic              w_is_empty;
  logic              w_is_full;
  logic              w_mem_we;
  logic [NBIDX-1:0]  w_wr_idx;
  logic [NBIDX-1:0]  w_rd_idx;

  assign w_push_only = dsp_push & ~dsp_pop;
  assign w_pop_only  = dsp_pop & ~dsp_push;
  assign w_replace   = dsp_push & dsp_pop;
  assign w_is_empty  = (r_count == '0);
  assign w_is_full   = (r_count == DEPTH_C);

  // A replace overwrites the current top slot; a plain push fills the next free slot.
  assign w_wr_idx = w_replace ? NBIDX'(r_count - ONE_C) : NBIDX'(r_count);
  assign w_rd_idx = NBIDX'(r_count - TWO_C);
  assign w_mem_we = rst & ~clr &
                    ((w_push_only & ~w_is_full) | (w_replace & ~w_is_empty));

  // Entry storage carries no reset; slots at or above count are never observed.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_wr_idx] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_top   <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_top   <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (w_push_only) begin
      if (w_is_full) begin
        r_ovf <= 1'b1;
      end else begin
        r_count <= r_count + ONE_C;
        r_top   <= data_in;
      end
    end else if (w_pop_only) begin
      if (w_is_empty) begin
        r_udf <= 1'b1;
      end else if (r_count == ONE_C) begin
        r_count <= '0;
        r_top   <= '0;
      end else begin
        r_count <= r_count - ONE_C;
        r_top   <= r_mem[w_rd_idx];
      end
    end else if (w_replace) begin
      if (w_is_empty) begin
        r_udf <= 1'b1;
      end else begin
        r_top <= data_in;
      end
    end
  end

  assign data_out = r_top;
  assign count    = r_count;
  assign empty    = w_is_empty;
  assign full     = w_is_full;
  assign ovf      = r_ovf;
  assign udf      = r_udf;

endmodule

// File: tb/tb_data_stack.sv
// Self-checking bench for data_stack: queue-based reference model compared every
// cycle, plus literal checkpoints for the fill/drain, error, replace and reset cases.
module tb_data_stack;
  localparam int NBDATA = 32;
  localparam int SDEPTH = 10;
  localparam int NBCNT  = $clog2(SDEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              dsp_push = 1'b0;
  logic              dsp_pop = 1'b0;
  logic              clr = 1'b0;
  logic [NBDATA-1:0] data_in = '0;
  logic [NBDATA-1:0] data_out;
  logic [NBCNT-1:0]  count;
  logic              empty, full, ovf, udf;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the stack is simply a queue whose back is the top.
  logic [NBDATA-1:0] m_q[$];
  logic              m_ovf = 1'b0;
  logic              m_udf = 1'b0;

  data_stack #(.NBDATA(NBDATA), .SDEPTH(SDEPTH)) dut (
    .clk(clk), .rst(rst), .dsp_push(dsp_push), .dsp_pop(dsp_pop), .clr(clr),
    .data_in(data_in), .data_out(data_out), .count(count), .empty(empty),
    .full(full), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [NBDATA-1:0] act, input logic [NBDATA-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NBDATA-1:0] m_top();
    return (m_q.size() == 0) ? '0 : m_q[m_q.size()-1];
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic m_apply(input logic p, input logic q, input logic c, input logic [NBDATA-1:0] d);
    if (c) begin
      m_reset();
    end else if (p && !q) begin
      if (m_q.size() < SDEPTH) m_q.push_back(d);
      else m_ovf = 1'b1;
    end else if (q && !p) begin
      if (m_q.size() == 0) m_udf = 1'b1;
      else void'(m_q.pop_back());
    end else if (p && q) begin
      if (m_q.size() == 0) m_udf = 1'b1;
      else m_q[m_q.size()-1] = d;
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("cyc_data_out", data_out, m_top());
    chk("cyc_count", NBDATA'(count), NBDATA'(m_q.size()));
    chk("cyc_empty", NBDATA'(empty), NBDATA'(m_q.size() == 0));
    chk("cyc_full", NBDATA'(full), NBDATA'(m_q.size() == SDEPTH));
    chk("cyc_ovf", NBDATA'(ovf), NBDATA'(m_ovf));
    chk("cyc_udf", NBDATA'(udf), NBDATA'(m_udf));
  end

  task automatic step(input logic p, input logic q, input logic c, input logic [NBDATA-1:0] d);
    @(negedge clk);
    #1;
    dsp_push = p; dsp_pop = q; clr = c; data_in = d;
    @(posedge clk);
    m_apply(p, q, c, d);
    #1;
    dsp_push = 1'b0; dsp_pop = 1'b0; clr = 1'b0;
    $display("[TB] op push=%0b pop=%0b clr=%0b din=0x%0h -> count=%0d dout=0x%0h ovf=%0b udf=%0b",
             p, q, c, d, count, data_out, ovf, udf);
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    chk("reset_count", NBDATA'(count), 0);
    chk("reset_empty", NBDATA'(empty), 1);

    // Fill 1..10 then drain.
    for (int i = 1; i <= SDEPTH; i++) step(1, 0, 0, NBDATA'(i));
    chk("fill_count", NBDATA'(count), 10);
    chk("fill_full", NBDATA'(full), 1);
    chk("fill_top", data_out, 10);
    for (int i = 1; i <= SDEPTH; i++) begin
      step(0, 1, 0, 0);
      chk("drain_top", data_out, NBDATA'(10 - i));
    end
    chk("drain_empty", NBDATA'(empty), 1);
    chk("drain_flags", NBDATA'({ovf, udf}), 0);

    // Overflow.
    for (int i = 1; i <= SDEPTH; i++) step(1, 0, 0, NBDATA'(i));
    step(1, 0, 0, 32'hDEAD);
    chk("ovf_flag", NBDATA'(ovf), 1);
    chk("ovf_count", NBDATA'(count), 10);
    chk("ovf_top", data_out, 10);
    step(0, 1, 0, 0);
    chk("ovf_pop_top", data_out, 9);
    chk("ovf_sticky", NBDATA'(ovf), 1);
    step(1, 1, 0, 32'h77);
    chk("replace_full_top", data_out, 32'h77);

    // Clear with count=3, ovf=1, plus a push on the same edge.
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
    chk("pre_clr_count", NBDATA'(count), 3);
    step(1, 0, 1, 4);
    chk("clr_count", NBDATA'(count), 0);
    chk("clr_top", data_out, 0);
    chk("clr_ovf", NBDATA'(ovf), 0);

    // Underflow.
    step(0, 1, 0, 0);
    chk("udf_flag", NBDATA'(udf), 1);
    chk("udf_count", NBDATA'(count), 0);
    step(1, 1, 0, 32'h55);
    chk("udf_pp_count", NBDATA'(count), 0);
    chk("udf_pp_top", data_out, 0);

    // Replace.
    step(1, 0, 0, 5);
    step(1, 0, 0, 7);
    step(1, 1, 0, 9);
    chk("rep_count", NBDATA'(count), 2);
    chk("rep_top", data_out, 9);
    step(0, 1, 0, 0);
    chk("rep_pop_top", data_out, 5);
    chk("udf_sticky", NBDATA'(udf), 1);

    // Asynchronous reset mid-cycle with count=6.
    step(0, 0, 1, 0);
    for (int i = 1; i <= 6; i++) step(1, 0, 0, NBDATA'(32'h100 + i));
    chk("pre_rst_count", NBDATA'(count), 6);
    #2 rst = 1'b0;
    m_reset();
    #1;
    chk("arst_count", NBDATA'(count), 0);
    chk("arst_top", data_out, 0);
    chk("arst_empty", NBDATA'(empty), 1);
    @(negedge clk);
    #1 rst = 1'b1;
    step(1, 0, 0, 32'h11);
    chk("post_rst_count", NBDATA'(count), 1);
    chk("post_rst_top", data_out, 32'h11);

    // Mixed back-to-back burst checked only by the per-cycle model comparison.
    for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'(i == 25), $urandom);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
